// File: rtl/instruction_loader_if.sv
// Stream, instruction-memory write and core-control signals of the boot loader.
interface instruction_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    // The loader is the slave of the byte stream and drives memory/core control.
    modport slave (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, core_rst, done, err
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, core_rst, done, err
    );
endinterface

// File: rtl/instruction_loader.sv
// Boot loader: byte stream -> big-endian 16-bit words -> instruction memory, then core release.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module instruction_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    instruction_loader_if.slave bus
);
    localparam int               IDX_W    = ADDR_W + 1;
    localparam logic [16:0]      CAPACITY = 17'(1) << ADDR_W;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_DRAIN,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_RUN,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_hi_q;
    logic [7:0]        data_hi_q;
    logic [IDX_W-1:0]  word_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [15:0]       im_wdata_q;
    logic              done_q;
    logic              err_q;

    logic              ready_c;
    logic              in_ready;
    logic              accept;
    logic [15:0]       count_in;
    logic              count_too_big;
    logic              count_zero;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    assign in_ready      = ready_c & ~rst;
    assign accept        = bus.in_valid & in_ready;
    assign count_in      = {cnt_hi_q, bus.in_data};
    assign count_too_big = {1'b0, count_in} > CAPACITY;
    assign count_zero    = (count_in == 16'd0);
    assign last_word     = (idx_q + IDX_ONE) == word_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= ST_CNT_HI;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_d = state_q;
        ready_c = 1'b0;
        unique case (state_q)
            ST_CNT_HI: begin
                ready_c = 1'b1;
                if (accept) state_d = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                ready_c = 1'b1;
                if (accept) begin
                    if (count_too_big) state_d = ST_ERR;
`ifdef LOADER_CHECKSUM_EN
                    else if (count_zero) state_d = ST_CHK;
`else
                    else if (count_zero) state_d = ST_RUN;
`endif
                    else state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                ready_c = 1'b1;
                if (accept) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                ready_c = 1'b1;
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = last_word ? ST_CHK : ST_DATA_HI;
`else
                    state_d = last_word ? ST_DRAIN : ST_DATA_HI;
`endif
                end
            end
            // One idle cycle lets the final write land before core_rst can fall.
            ST_DRAIN: state_d = ST_RUN;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                ready_c = 1'b1;
                if (accept) state_d = (bus.in_data == chk_q) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_CNT_HI;
        endcase
    end

    // Datapath registers are reset because the memory port and status outputs have defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_hi_q   <= 8'h00;
            data_hi_q  <= 8'h00;
            word_cnt_q <= '0;
            idx_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            done_q  <= (state_q == ST_RUN);
            err_q   <= (state_q == ST_ERR);
            if (accept) begin
                unique case (state_q)
                    ST_CNT_HI:  cnt_hi_q   <= bus.in_data;
                    ST_CNT_LO:  word_cnt_q <= count_in[IDX_W-1:0];
                    ST_DATA_HI: data_hi_q  <= bus.in_data;
                    ST_DATA_LO: begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= idx_q[ADDR_W-1:0];
                        im_wdata_q <= {data_hi_q, bus.in_data};
                        idx_q      <= idx_q + IDX_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every byte from COUNT_HI through the last payload byte.
    always_ff @(posedge clk) begin
        if (rst)                             chk_q <= 8'h00;
        else if (accept && state_q != ST_CHK) chk_q <= chk_q ^ bus.in_data;
    end
`endif

    assign bus.in_ready = in_ready;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.core_rst = ~done_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader; memory writes checked against a scoreboard queue.
// Follows the DUT build: define LOADER_CHECKSUM_EN for both or neither.
module tb_instruction_loader;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wr_t         exp_q[$];
    logic [15:0] img[$];
    logic [7:0]  xsum;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instruction_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    instruction_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every im_we pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (ifc.im_we === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("im_addr", 32'(ifc.im_addr), 32'(e.addr));
                check("im_wdata", 32'(ifc.im_wdata), 32'(e.data));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Called right after a falling edge; returns right after the falling edge following the accept.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) @(negedge clk);
        ifc.in_data  = b;
        ifc.in_valid = 1'b1;
        xsum         = xsum ^ b;
        while (ifc.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int idx, input int gap);
        wr_t e;
        send_byte(w[15:8], gap);
        e.addr = ADDR_W'(idx);
        e.data = w;
        exp_q.push_back(e);
        send_byte(w[7:0], gap);
        check("im_we_latency", 32'(ifc.im_we), 32'd1);
    endtask

    task automatic load_image(input int gap);
        logic [15:0] n;
        n    = 16'(img.size());
        xsum = 8'h00;
        send_byte(n[15:8], 0);
        send_byte(n[7:0], gap);
        foreach (img[i]) send_word(img[i], i, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(xsum, gap);
`endif
    endtask

    function automatic int release_latency(input int n);
`ifdef LOADER_CHECKSUM_EN
        return 1;
`else
        return (n == 0) ? 1 : 2;
`endif
    endfunction

    // Entered right after the falling edge that follows the final accepted byte.
    task automatic expect_release(input int lat);
        check("done_early", 32'(ifc.done), 32'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("done_early", 32'(ifc.done), 32'd0);
            check("core_rst_early", 32'(ifc.core_rst), 32'd1);
        end
        @(negedge clk);
        check("done", 32'(ifc.done), 32'd1);
        check("core_rst", 32'(ifc.core_rst), 32'd0);
        check("err", 32'(ifc.err), 32'd0);
        check("in_ready_run", 32'(ifc.in_ready), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_im_we", 32'(ifc.im_we), 32'd0);
        check("rst_im_addr", 32'(ifc.im_addr), 32'd0);
        check("rst_im_wdata", 32'(ifc.im_wdata), 32'd0);
        check("rst_core_rst", 32'(ifc.core_rst), 32'd1);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_err", 32'(ifc.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin : stimulus
        ifc.in_data  = 8'h00;
        ifc.in_valid = 1'b0;
        xsum         = 8'h00;

        // Three words, back-to-back bytes.
        do_reset();
        img = '{16'h1234, 16'hABCD, 16'h0000};
        load_image(0);
        expect_release(release_latency(3));

        // Bytes offered in RUN are ignored: no writes, core stays released.
        ifc.in_data  = 8'h5A;
        ifc.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        ifc.in_valid = 1'b0;
        check("run_hold_done", 32'(ifc.done), 32'd1);

        // Same image with in_valid low every other cycle.
        do_reset();
        load_image(1);
        expect_release(release_latency(3));

        // Empty image.
        do_reset();
        img.delete();
        load_image(0);
        expect_release(release_latency(0));

        // N = 257 exceeds capacity.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("ovf_in_ready", 32'(ifc.in_ready), 32'd0);
        check("ovf_err_early", 32'(ifc.err), 32'd0);
        @(negedge clk);
        check("ovf_err", 32'(ifc.err), 32'd1);
        check("ovf_core_rst", 32'(ifc.core_rst), 32'd1);
        check("ovf_done", 32'(ifc.done), 32'd0);
        ifc.in_data  = 8'h00;
        ifc.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        ifc.in_valid = 1'b0;
        check("ovf_err_hold", 32'(ifc.err), 32'd1);
        check("ovf_done_hold", 32'(ifc.done), 32'd0);

        // N = 256 fills memory exactly.
        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back({8'(i) ^ 8'hA5, 8'(i)});
        load_image(0);
        expect_release(release_latency(256));

        // Reset after two words of a four-word image, then a fresh two-word load.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(16'h1111, 0, 0);
        send_word(16'h2222, 1, 0);
        do_reset();
        check("midrst_sb", 32'(exp_q.size()), 32'd0);
        img = '{16'hCAFE, 16'hBEEF};
        load_image(0);
        expect_release(release_latency(2));

`ifdef LOADER_CHECKSUM_EN
        // One word 0x1234 with correct checksum 0x27.
        do_reset();
        begin
            wr_t e;
            e.addr = '0;
            e.data = 16'h1234;
            exp_q.push_back(e);
        end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h27, 0);
        expect_release(1);

        // Same word with wrong checksum 0x26.
        do_reset();
        begin
            wr_t e;
            e.addr = '0;
            e.data = 16'h1234;
            exp_q.push_back(e);
        end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h26, 0);
        check("chk_in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        check("chk_err", 32'(ifc.err), 32'd1);
        check("chk_done", 32'(ifc.done), 32'd0);
        check("chk_core_rst", 32'(ifc.core_rst), 32'd1);
        check("chk_sb", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_final", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
